// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_WB         = 3'd5,
    ST_HALT       = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_IFETCH  = 2'd1,
    TRAP_LSU     = 2'd2,
    TRAP_TIMEOUT = 2'd3
  } trap_cause_t;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] DEF_PC_RESET = 32'h8000_0000;

  // States that wait on a bus and are therefore guarded by the watchdog.
  function automatic logic is_bus_state(input seq_state_t s);
    return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) ||
           (s == ST_MEM_REQ)   || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/seq_wdog.sv
// Bus watchdog: counts enabled cycles, cleared on every sequencer state change.
module seq_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mc_core_seq.sv
// Multi-cycle instruction sequencer: owns the PC and steps each instruction
// through fetch/execute/memory/writeback with handshaked memories.
module mc_core_seq
  import core_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] PC_RESET    = XLEN'(DEF_PC_RESET),
  parameter int unsigned     TIMEOUT_CYC = 1024,
  parameter int unsigned     CNT_W       = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             ifu_req_valid_o,
  input  logic             ifu_req_ready_i,
  output logic [XLEN-1:0]  ifu_addr_o,
  input  logic             ifu_resp_valid_i,
  input  logic [31:0]      ifu_resp_inst_i,
  input  logic             ifu_resp_err_i,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  pc_o,
  input  logic             idu_is_load_i,
  input  logic             idu_is_store_i,
  input  logic             idu_wen_reg_i,
  input  logic             idu_is_ebreak_i,
  input  logic [XLEN-1:0]  exu_npc_i,
  output logic             lsu_req_valid_o,
  input  logic             lsu_req_ready_i,
  input  logic             lsu_resp_valid_i,
  input  logic             lsu_resp_err_i,
  input  logic [XLEN-1:0]  lsu_rdata_i,
  output logic [XLEN-1:0]  ld_data_o,
  output logic             reg_wen_o,
  output logic             commit_o,
  output logic             halt_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  seq_state_t       state_q, state_d;
  trap_cause_t      cause_q, cause_d;
  logic [XLEN-1:0]  pc_q, npc_q, ld_data_q;
  logic [31:0]      inst_q;
  logic [CNT_W-1:0] instret_q;
  logic             halt_q, trap_q;
  logic             set_halt, set_trap, inst_en, ld_en;
  logic             wdog_expire;

  seq_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_d != state_q),
    .en_i     (is_bus_state(state_q)),
    .expire_o (wdog_expire)
  );

  // Handshakes and responses are tested before the watchdog so they win a tie.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    set_halt = 1'b0;
    set_trap = 1'b0;
    inst_en  = 1'b0;
    ld_en    = 1'b0;
    unique case (state_q)
      ST_FETCH_REQ: begin
        if (ifu_req_ready_i) begin
          state_d = ST_FETCH_WAIT;
        end else if (wdog_expire) begin
          state_d  = ST_HALT;
          set_trap = 1'b1;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      ST_FETCH_WAIT: begin
        if (ifu_resp_valid_i) begin
          if (ifu_resp_err_i) begin
            state_d  = ST_HALT;
            set_trap = 1'b1;
            cause_d  = TRAP_IFETCH;
          end else begin
            inst_en = 1'b1;
            state_d = ST_EXEC;
          end
        end else if (wdog_expire) begin
          state_d  = ST_HALT;
          set_trap = 1'b1;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (idu_is_load_i || idu_is_store_i) begin
          state_d = ST_MEM_REQ;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        if (lsu_req_ready_i) begin
          state_d = ST_MEM_WAIT;
        end else if (wdog_expire) begin
          state_d  = ST_HALT;
          set_trap = 1'b1;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      ST_MEM_WAIT: begin
        if (lsu_resp_valid_i) begin
          if (lsu_resp_err_i) begin
            state_d  = ST_HALT;
            set_trap = 1'b1;
            cause_d  = TRAP_LSU;
          end else begin
            ld_en   = idu_is_load_i;
            state_d = ST_WB;
          end
        end else if (wdog_expire) begin
          state_d  = ST_HALT;
          set_trap = 1'b1;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      ST_WB: begin
        if (idu_is_ebreak_i) begin
          state_d  = ST_HALT;
          set_halt = 1'b1;
        end else begin
          state_d = ST_FETCH_REQ;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH_REQ;
      pc_q      <= PC_RESET;
      npc_q     <= PC_RESET;
      inst_q    <= NOP_INST;
      ld_data_q <= '0;
      instret_q <= '0;
      halt_q    <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (inst_en) inst_q <= ifu_resp_inst_i;
      // npc is captured in EXEC so a WB write to rs1 cannot disturb the PC update.
      if (state_q == ST_EXEC) npc_q <= exu_npc_i;
      if (ld_en) ld_data_q <= lsu_rdata_i;
      if (state_q == ST_WB) begin
        pc_q      <= npc_q;
        instret_q <= instret_q + CNT_W'(1);
      end
      if (set_halt) halt_q <= 1'b1;
      if (set_trap) trap_q <= 1'b1;
    end
  end

  // Fetch strobe is masked while reset is held so no request escapes during it.
  assign ifu_req_valid_o = (state_q == ST_FETCH_REQ) && !rst_i;
  assign lsu_req_valid_o = (state_q == ST_MEM_REQ);
  assign commit_o        = (state_q == ST_WB);
  assign reg_wen_o       = commit_o && idu_wen_reg_i && !idu_is_store_i;
  assign ifu_addr_o      = pc_q;
  assign pc_o            = pc_q;
  assign inst_o          = inst_q;
  assign ld_data_o       = ld_data_q;
  assign instret_o       = instret_q;
  assign halt_o          = halt_q;
  assign trap_o          = trap_q;
  assign trap_cause_o    = cause_q;

endmodule

// File: tb/tb_mc_core_seq.sv
// Directed self-checking bench for mc_core_seq with a short watchdog.
module tb_mc_core_seq;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;
  localparam int unsigned TMO   = 8;

  localparam logic [31:0] ADDI   = 32'h0010_8093;
  localparam logic [31:0] LW     = 32'h0002_a283;
  localparam logic [31:0] SW     = 32'h0052_a023;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] BADNPC = 32'hBAD0_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             ifu_req_valid, ifu_req_ready;
  logic [XLEN-1:0]  ifu_addr;
  logic             ifu_resp_valid, ifu_resp_err;
  logic [31:0]      ifu_resp_inst, inst_o;
  logic [XLEN-1:0]  pc_o, exu_npc, lsu_rdata, ld_data;
  logic             idu_is_load, idu_is_store, idu_wen_reg, idu_is_ebreak;
  logic             lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic             reg_wen, commit, halt, trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int c0, c1, c2, cx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc_core_seq #(
    .XLEN        (XLEN),
    .PC_RESET    (32'h8000_0000),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ifu_req_valid_o  (ifu_req_valid),
    .ifu_req_ready_i  (ifu_req_ready),
    .ifu_addr_o       (ifu_addr),
    .ifu_resp_valid_i (ifu_resp_valid),
    .ifu_resp_inst_i  (ifu_resp_inst),
    .ifu_resp_err_i   (ifu_resp_err),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .idu_is_load_i    (idu_is_load),
    .idu_is_store_i   (idu_is_store),
    .idu_wen_reg_i    (idu_wen_reg),
    .idu_is_ebreak_i  (idu_is_ebreak),
    .exu_npc_i        (exu_npc),
    .lsu_req_valid_o  (lsu_req_valid),
    .lsu_req_ready_i  (lsu_req_ready),
    .lsu_resp_valid_i (lsu_resp_valid),
    .lsu_resp_err_i   (lsu_resp_err),
    .lsu_rdata_i      (lsu_rdata),
    .ld_data_o        (ld_data),
    .reg_wen_o        (reg_wen),
    .commit_o         (commit),
    .halt_o           (halt),
    .trap_o           (trap),
    .trap_cause_o     (trap_cause),
    .instret_o        (instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_err   = 1'b0;
    ifu_resp_inst  = '0;
    idu_is_load    = 1'b0;
    idu_is_store   = 1'b0;
    idu_wen_reg    = 1'b0;
    idu_is_ebreak  = 1'b0;
    exu_npc        = '0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_err   = 1'b0;
    lsu_rdata      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  // Starts in FETCH_REQ; ends in EXEC with the instruction latched.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input int unsigned stall);
    for (int unsigned k = 0; k < stall; k++) begin
      ifu_req_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid", ifu_req_valid, 1);
      chk("bp_addr", ifu_addr, pc);
      step();
    end
    ifu_req_ready = 1'b1;
    @(negedge clk);
    chk("fetch_valid", ifu_req_valid, 1);
    chk("fetch_addr", ifu_addr, pc);
    step();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = inst;
    @(negedge clk);
    chk("fetch_wait_no_req", ifu_req_valid, 0);
    step();
    ifu_resp_valid = 1'b0;
    chk("inst_latched", inst_o, inst);
  endtask

  // EXEC cycle; afterwards exu_npc is corrupted to prove it was latched.
  task automatic exec(input logic [31:0] npc, input logic ld, input logic st,
                      input logic wen, input logic ebr);
    idu_is_load   = ld;
    idu_is_store  = st;
    idu_wen_reg   = wen;
    idu_is_ebreak = ebr;
    exu_npc       = npc;
    step();
    exu_npc = BADNPC;
  endtask

  // MEM_REQ handshake, then respond on MEM_WAIT cycle lat.
  task automatic mem_phase(input int unsigned lat, input logic err, input logic [31:0] rdata);
    lsu_req_ready = 1'b1;
    @(negedge clk);
    chk("lsu_req_valid", lsu_req_valid, 1);
    step();
    lsu_req_ready = 1'b0;
    for (int unsigned k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("mem_wait_no_req", lsu_req_valid, 0);
      chk("mem_wait_no_wen", reg_wen, 0);
      chk("mem_wait_trap", trap, 0);
      step();
    end
    lsu_resp_valid = 1'b1;
    lsu_resp_err   = err;
    lsu_rdata      = rdata;
    step();
    lsu_resp_valid = 1'b0;
    lsu_resp_err   = 1'b0;
    lsu_rdata      = '0;
  endtask

  // WB cycle; returns the cycle number of the commit pulse.
  task automatic wb(input logic [31:0] npc, input logic exp_wen, output int ccyc);
    @(negedge clk);
    chk("wb_commit", commit, 1);
    chk("wb_reg_wen", reg_wen, exp_wen);
    ccyc = cyc;
    step();
    chk("wb_pc", pc_o, npc);
    chk("post_wb_commit", commit, 0);
    chk("post_wb_reg_wen", reg_wen, 0);
  endtask

  task automatic chk_quiet(input string tag);
    ifu_req_ready  = 1'b1;
    lsu_req_ready  = 1'b1;
    ifu_resp_valid = 1'b1;
    lsu_resp_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_ifu_valid"}, ifu_req_valid, 0);
      chk({tag, "_lsu_valid"}, lsu_req_valid, 0);
      chk({tag, "_commit"}, commit, 0);
      step();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset values.
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc_o, 32'h8000_0000);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_instret", instret, 0);
    chk("rst_ifu_valid", ifu_req_valid, 0);
    chk("rst_lsu_valid", lsu_req_valid, 0);
    chk("rst_commit", commit, 0);
    chk("rst_reg_wen", reg_wen, 0);
    chk("rst_halt", halt, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    rst = 1'b0;
    step();

    // Zero-wait ALU stream of three addi.
    fetch(32'h8000_0000, ADDI, 0);
    exec(32'h8000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
    wb(32'h8000_0004, 1'b1, c0);
    fetch(32'h8000_0004, ADDI, 0);
    exec(32'h8000_0008, 1'b0, 1'b0, 1'b1, 1'b0);
    wb(32'h8000_0008, 1'b1, c1);
    fetch(32'h8000_0008, ADDI, 0);
    exec(32'h8000_000C, 1'b0, 1'b0, 1'b1, 1'b0);
    wb(32'h8000_000C, 1'b1, c2);
    chk("alu_spacing_1", 64'(c1 - c0), 4);
    chk("alu_spacing_2", 64'(c2 - c1), 4);
    chk("alu_instret", instret, 3);

    // Backpressure on the first fetch, then a 3-cycle load with rd == rs1.
    do_reset();
    fetch(32'h8000_0000, LW, 5);
    exec(32'h8000_0004, 1'b1, 1'b0, 1'b1, 1'b0);
    mem_phase(3, 1'b0, 32'hDEAD_BEEF);
    chk("load_data", ld_data, 32'hDEAD_BEEF);
    wb(32'h8000_0004, 1'b1, cx);
    chk("load_instret", instret, 1);

    // Fetch error on the second instruction.
    ifu_req_ready = 1'b1;
    @(negedge clk);
    chk("ferr_addr", ifu_addr, 32'h8000_0004);
    step();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b1;
    ifu_resp_err   = 1'b1;
    step();
    clear_inputs();
    chk("ferr_trap", trap, 1);
    chk("ferr_cause", trap_cause, 1);
    chk("ferr_pc", pc_o, 32'h8000_0004);
    chk("ferr_instret", instret, 1);
    chk("ferr_halt", halt, 0);
    chk_quiet("ferr");

    // Store whose response never arrives: trap after 8 MEM_WAIT cycles.
    do_reset();
    fetch(32'h8000_0000, SW, 0);
    exec(32'h8000_0004, 1'b0, 1'b1, 1'b1, 1'b0);
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    for (int unsigned k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk("tmo_not_yet", trap, 0);
      step();
    end
    chk("tmo_trap", trap, 1);
    chk("tmo_cause", trap_cause, 3);
    chk("tmo_instret", instret, 0);
    chk_quiet("tmo");

    // Response on the expiry cycle wins; store does not write a register.
    do_reset();
    fetch(32'h8000_0000, SW, 0);
    exec(32'h8000_0004, 1'b0, 1'b1, 1'b1, 1'b0);
    mem_phase(TMO, 1'b0, 32'h0);
    wb(32'h8000_0004, 1'b0, cx);
    chk("late_resp_trap", trap, 0);
    chk("late_resp_instret", instret, 1);

    // Error response on the expiry cycle reports the bus error.
    do_reset();
    fetch(32'h8000_0000, SW, 0);
    exec(32'h8000_0004, 1'b0, 1'b1, 1'b1, 1'b0);
    mem_phase(TMO, 1'b1, 32'h0);
    chk("lsu_err_trap", trap, 1);
    chk("lsu_err_cause", trap_cause, 2);

    // ebreak retires, then halts.
    do_reset();
    fetch(32'h8000_0000, EBREAK, 0);
    exec(32'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1);
    wb(32'h8000_0004, 1'b0, cx);
    chk("ebreak_halt", halt, 1);
    chk("ebreak_trap", trap, 0);
    chk("ebreak_instret", instret, 1);
    chk_quiet("halt");

    // Asynchronous reset in MEM_WAIT.
    do_reset();
    fetch(32'h8000_0000, ADDI, 0);
    exec(32'h8000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
    wb(32'h8000_0004, 1'b1, cx);
    fetch(32'h8000_0004, LW, 0);
    exec(32'h8000_0008, 1'b1, 1'b0, 1'b1, 1'b0);
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc_o, 32'h8000_0000);
    chk("arst_instret", instret, 0);
    chk("arst_inst", inst_o, 32'h0000_0013);
    chk("arst_commit", commit, 0);
    chk("arst_reg_wen", reg_wen, 0);
    chk("arst_lsu_valid", lsu_req_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    step();
    fetch(32'h8000_0000, ADDI, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
